// File: rtl/nn_ctrl_pkg.sv
// Shared types and sizing for the neural-net layer controllers.
// Holds the scan-FSM state encoding and the mm4 output-memory geometry.
package nn_ctrl_pkg;

    localparam int MM4_NUM_CLASSES = 10;
    localparam int MM4_DATA_WIDTH  = 32;
    localparam int MM4_ADDR_WIDTH  = 16;
    localparam int MM4_IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/mm4_argmax_ctrl_if.sv
// Handshake/memory bundle between the mm4 argmax sequencer and its
// surroundings (layer controller, score memory, classification output).
interface mm4_argmax_ctrl_if
    import nn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = MM4_DATA_WIDTH,
    parameter int ADDR_WIDTH = MM4_ADDR_WIDTH,
    parameter int IDX_WIDTH  = MM4_IDX_WIDTH
);

    logic                  start;
    logic                  wr_active;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  busy;
    logic                  done;
    logic [IDX_WIDTH-1:0]  class_idx;
    logic [DATA_WIDTH-1:0] max_value;

    modport master (
        output start,
        output wr_active,
        input  mem_read_addr,
        output mem_data_in,
        input  busy,
        input  done,
        input  class_idx,
        input  max_value
    );

    modport slave (
        input  start,
        input  wr_active,
        output mem_read_addr,
        input  mem_data_in,
        output busy,
        output done,
        output class_idx,
        output max_value
    );

endinterface

// File: rtl/signed_max_cmp.sv
// Combinational two's-complement compare: is candidate strictly above max?
// Strict so that on ties the earlier-seen value is kept.
module signed_max_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] candidate,
    input  logic [WIDTH-1:0] current_max,
    output logic             greater
);

    assign greater = $signed(candidate) > $signed(current_max);

endmodule

// File: rtl/mm4_argmax_ctrl.sv
// Scans the mm4 class-score memory and reports the argmax class.
// Stalls on memory writes so it never reads a word mid-update.
module mm4_argmax_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES = MM4_NUM_CLASSES,
    parameter int DATA_WIDTH  = MM4_DATA_WIDTH,
    parameter int ADDR_WIDTH  = MM4_ADDR_WIDTH,
    parameter int IDX_WIDTH   = MM4_IDX_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    mm4_argmax_ctrl_if.slave  bus
);

    state_t                state;
    logic [IDX_WIDTH-1:0]  addr_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  greater;
    logic                  last;

    signed_max_cmp #(
        .WIDTH (DATA_WIDTH)
    ) u_cmp (
        .candidate   (bus.mem_data_in),
        .current_max (max_q),
        .greater     (greater)
    );

    assign last = (addr_q == IDX_WIDTH'(NUM_CLASSES - 1));

    // Counter is only IDX_WIDTH wide, so upper address bits stay zero.
    assign bus.mem_read_addr = ADDR_WIDTH'(addr_q);
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.class_idx     = idx_q;
    assign bus.max_value     = max_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            idx_q  <= '0;
            max_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!bus.wr_active) begin
                        // First word seeds the max regardless of its value.
                        if (addr_q == '0 || greater) begin
                            max_q <= bus.mem_data_in;
                            idx_q <= addr_q;
                        end
                        if (last) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            addr_q <= addr_q + IDX_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        addr_q <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
